uart_rx_frontend: RTL and testbench

- Serial receive front end for the CPU's memory-mapped peripheral block.
- Converts the asynchronous UART_RX pin into bytes held in a status/data holding register. The peripheral reads the byte, sees its status flags, and clears it through `rx_ack`.
- Frame format is 8N1, LSB first, oversampled at 16x.
- Sits directly upstream of the peripheral's UART read path and runs in the `sysclk` domain.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_frontend_baud_tick.sv | 42 ++++
 rtl/uart_rx_frontend.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud divider helper
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int HALF_BIT   = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

    // sysclk cycles per oversample tick, rounded to nearest integer
    function automatic int calc_tick_div(input int clk_freq, input int baud);
        int per_sec;
        per_sec = baud * OVERSAMPLE;
        return (clk_freq + per_sec / 2) / per_sec;
    endfunction

endpackage

// File: rtl/uart_rx_frontend_baud_tick.sv
// rtl/uart_rx_frontend_baud_tick.sv - free-running oversample tick divider with sync clear
//
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset, counter to 0
//   clear : synchronous clear, counter to 0 (restarts tick phase)
//   tick  : high for one cycle when the counter equals DIV-1
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - 8N1 16x-oversampled UART receiver with holding register
//
// Ports:
//   sysclk    : clock
//   reset     : synchronous active-high reset
//   uart_rxd  : asynchronous serial input, idles high
//   rx_ack    : one-cycle pulse, clears rx_valid / overrun / frame_err
//   rx_data   : last correctly framed byte
//   rx_valid  : sticky, a byte has landed in rx_data
//   overrun   : sticky, a byte landed while rx_valid was already set
//   frame_err : sticky, a stop bit was sampled low
//   busy      : receiver FSM is not idle
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       uart_rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD);
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_START   = 4'(HALF_BIT - 1);

    logic        sync1_q, sync2_q;
    logic        rxs;
    uart_state_e state_q, state_d;
    logic [3:0]  sample_cnt_q, sample_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic        frame_err_q, frame_err_d;
    logic        busy_q, busy_d;

    logic        tick;
    logic        tick_clear;
    logic        byte_ok;
    logic        byte_bad;

    assign rxs = sync2_q;

    // Restart the tick phase on the start edge so the mid-bit samples line up
    assign tick_clear = (state_q == ST_IDLE) && !rxs;

    uart_baud_tick #(
        .DIV (TICK_DIV)
    ) u_baud_tick (
        .clk   (sysclk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_ok      = 1'b0;
        byte_bad     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d      = ST_START;
                    sample_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (sample_cnt_q == MID_START) begin
                        sample_cnt_d = '0;
                        bit_idx_d    = '0;
                        state_d      = rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                    if (sample_cnt_q == LAST_SAMPLE) begin
                        sample_cnt_d = '0;
                        shift_d      = {rxs, shift_q[7:1]};
                        bit_idx_d    = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = ST_STOP;
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    sample_cnt_d = sample_cnt_q + 4'd1;
                    if (sample_cnt_q == LAST_SAMPLE) begin
                        sample_cnt_d = '0;
                        if (rxs) begin
                            byte_ok = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            byte_bad = 1'b1;
                            state_d  = ST_WAIT_HIGH;
                        end
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low line (break) must not look like a fresh start bit
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register: ack clears first, a same-cycle event then sets on top
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;

        if (rx_ack) begin
            rx_valid_d  = 1'b0;
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (byte_ok) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ack) begin
                overrun_d = 1'b1;
            end
        end
        if (byte_bad) begin
            frame_err_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= uart_rxd;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb/tb_uart_rx_frontend.sv - self-checking bench for uart_rx_frontend
module tb_uart_rx_frontend;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    // driving edge to flag update: 2 sync + 1 idle detect + 8 ticks + 9 bits of 16 ticks
    localparam int DONE_EDGE = 2 + 1 + 8 * 10 + 9 * BIT_CYC;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       uart_rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ovr;
    logic       exp_ferr;

    always #5 sysclk = ~sysclk;

    uart_rx_frontend #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .uart_rxd  (uart_rxd),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_busy);
        check({tag, ".rx_data"},   {24'd0, rx_data},   {24'd0, exp_data});
        check({tag, ".rx_valid"},  {31'd0, rx_valid},  {31'd0, exp_valid});
        check({tag, ".overrun"},   {31'd0, overrun},   {31'd0, exp_ovr});
        check({tag, ".frame_err"}, {31'd0, frame_err}, {31'd0, exp_ferr});
        check({tag, ".busy"},      {31'd0, busy},      {31'd0, exp_busy});
    endtask

    // Reference model of the holding register
    task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic ack_same);
        if (ack_same) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
            exp_ferr  = 1'b0;
        end
        if (stop_ok) begin
            if (exp_valid) exp_ovr = 1'b1;
            exp_data  = b;
            exp_valid = 1'b1;
        end else begin
            exp_ferr = 1'b1;
        end
    endtask

    task automatic model_ack();
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        exp_ferr  = 1'b0;
    endtask

    // Called #1 after a posedge; each bit held for BIT_CYC edges, line left at stop value
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            repeat (BIT_CYC) @(posedge sysclk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(posedge sysclk);
        #1;
        rx_ack = 1'b0;
        model_ack();
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       stop_ok;

        reset    = 1'b1;
        uart_rxd = 1'b1;
        rx_ack   = 1'b0;
        exp_data = 8'h00;
        model_ack();
        repeat (3) @(posedge sysclk);
        #1;
        reset = 1'b0;
        check_all("reset", 1'b0);
        idle(5);

        // 1: clean 0x55, busy during frame
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (800) @(posedge sysclk);
                #1;
                check("s1.busy_mid", {31'd0, busy}, 32'd1);
            end
        join
        model_frame(8'h55, 1'b1, 1'b0);
        check_all("s1", 1'b0);
        ack_pulse();
        check_all("s1.ack", 1'b0);
        idle(10);

        // 2: 40-cycle glitch rejected
        uart_rxd = 1'b0;
        repeat (20) @(posedge sysclk);
        #1;
        check("s2.busy_hi", {31'd0, busy}, 32'd1);
        repeat (20) @(posedge sysclk);
        #1;
        uart_rxd = 1'b1;
        repeat (60) @(posedge sysclk);
        #1;
        check_all("s2", 1'b0);

        // 3: framing error then break held low
        send_frame(8'hA3, 1'b0);
        repeat (500) @(posedge sysclk);
        #1;
        model_frame(8'hA3, 1'b0, 1'b0);
        check_all("s3.break", 1'b1);
        idle(5);
        check_all("s3.release", 1'b0);
        ack_pulse();
        idle(10);

        // 4: overrun
        send_frame(8'h12, 1'b1);
        model_frame(8'h12, 1'b1, 1'b0);
        idle(10);
        send_frame(8'h34, 1'b1);
        model_frame(8'h34, 1'b1, 1'b0);
        check_all("s4.ovr", 1'b0);
        ack_pulse();
        check_all("s4.ack", 1'b0);
        idle(10);

        // 5: ack in the completion cycle of a second byte
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1, 1'b0);
        idle(10);
        fork
            send_frame(8'h7E, 1'b1);
            begin
                repeat (DONE_EDGE - 1) @(posedge sysclk);
                #1;
                rx_ack = 1'b1;
                @(posedge sysclk);
                #1;
                rx_ack = 1'b0;
            end
        join
        model_frame(8'h7E, 1'b1, 1'b1);
        check_all("s5", 1'b0);
        idle(10);

        // 6: reset during bit 4, then a clean 0xC9
        uart_rxd = 1'b0;
        repeat (5 * BIT_CYC) @(posedge sysclk);
        #1;
        uart_rxd = 1'b1;
        repeat (BIT_CYC / 2) @(posedge sysclk);
        #1;
        check("s6.busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge sysclk);
        #1;
        reset = 1'b0;
        exp_data = 8'h00;
        model_ack();
        check_all("s6.reset", 1'b0);
        idle(300);
        check_all("s6.quiet", 1'b0);
        send_frame(8'hC9, 1'b1);
        model_frame(8'hC9, 1'b1, 1'b0);
        check_all("s6.c9", 1'b0);
        idle(10);

        // randomized frames, stop bits and acks
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                ack_pulse();
                check_all("rnd.ack", 1'b0);
            end
            b       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 3) != 0);
            send_frame(b, stop_ok);
            model_frame(b, stop_ok, 1'b0);
            check_all("rnd.frame", stop_ok ? 1'b0 : 1'b1);
            idle($urandom_range(10, 40));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
